uart_tx_arbiter: RTL and testbench

Round-robin scheduler that shares one `uart_transmitter` instance between `NUM_REQ` byte producers, such as the debug console, the status reporter and the bootloader echo. It accepts one byte at a time from each requester over a valid/ready handshake. It drives the transmitter's `data_in`/`data_valid` and tracks its `ready` so that exactly one byte is issued per UART frame. Optional packet locking keeps a multi-byte message from one requester contiguous on the line, and a burst cap bounds how long any one requester can hold the line.

---
 rtl/uart_pkg.sv | 19 +
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 166 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: data width and the
// arbiter state encoding.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    localparam logic [1:0] ARB_IDLE      = 2'd0;
    localparam logic [1:0] ARB_ISSUE     = 2'd1;
    localparam logic [1:0] ARB_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ARB_WAIT_DONE = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE      = ARB_IDLE,
        ST_ISSUE     = ARB_ISSUE,
        ST_WAIT_ACK  = ARB_WAIT_ACK,
        ST_WAIT_DONE = ARB_WAIT_DONE
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: returns the first set request at or after ptr_i,
// wrapping modulo NUM_REQ, as a one-hot grant plus a found flag.
module rr_pick #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               found_o
);

    logic [IDX_W-1:0] sel_s;
    logic             hit_s;
    int               cand_s;

    // Walk the requests starting at the pointer; the first hit wins.
    always_comb begin
        grant_o = {NUM_REQ{1'b0}};
        found_o = 1'b0;
        sel_s   = {IDX_W{1'b0}};
        hit_s   = 1'b0;
        cand_s  = 0;
        for (int off = 0; off < NUM_REQ; off++) begin
            cand_s = int'(ptr_i) + off;
            cand_s = (cand_s >= NUM_REQ) ? (cand_s - NUM_REQ) : cand_s;
            sel_s  = IDX_W'(cand_s);
            hit_s  = (!found_o) && req_i[sel_s];
            grant_o[sel_s] = grant_o[sel_s] | hit_s;
            found_o = found_o | hit_s;
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter among NUM_REQ byte producers. Round-robin
// arbitration, optional packet lock with a burst cap, and one byte issued
// per UART frame by tracking the transmitter's ready handshake.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int MAX_BURST = 16,
    localparam int IDX_W     = $clog2(NUM_REQ),
    localparam int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [NUM_REQ*UART_DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic [UART_DATA_W-1:0]         tx_data_in,
    output logic                           tx_data_valid,
    input  logic                           tx_ready,
    output logic [IDX_W-1:0]               grant_idx,
    output logic                           grant_active,
    output logic                           busy
);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
    logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;
    logic                   lock_q, lock_d;
    logic [UART_DATA_W-1:0] tx_data_q, tx_data_d;
    logic                   tx_valid_q, tx_valid_d;

    logic [NUM_REQ-1:0]     owner_mask_s;
    logic [NUM_REQ-1:0]     eligible_s;
    logic [IDX_W-1:0]       pick_ptr_s;
    logic [NUM_REQ-1:0]     pick_grant_s;
    logic                   pick_found_s;
    logic [IDX_W-1:0]       winner_idx_s;
    logic [UART_DATA_W-1:0] winner_data_s;
    logic                   winner_last_s;
    logic                   accept_s;
    logic [CNT_W-1:0]       burst_inc_s;

    // While locked only the owner may win; otherwise everybody competes
    // starting from the round-robin pointer.
    always_comb begin
        owner_mask_s = {{(NUM_REQ-1){1'b0}}, 1'b1} << grant_idx_q;
        eligible_s   = lock_q ? (req_valid & owner_mask_s) : req_valid;
        pick_ptr_s   = lock_q ? grant_idx_q : rr_ptr_q;
    end

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_i   (eligible_s),
        .ptr_i   (pick_ptr_s),
        .grant_o (pick_grant_s),
        .found_o (pick_found_s)
    );

    // Reduce the one-hot grant to the winner's index, byte and last flag.
    always_comb begin
        winner_idx_s  = {IDX_W{1'b0}};
        winner_data_s = {UART_DATA_W{1'b0}};
        winner_last_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            winner_idx_s  = winner_idx_s | (IDX_W'(i) & {IDX_W{pick_grant_s[i]}});
            winner_data_s = winner_data_s
                          | (req_data[i*UART_DATA_W +: UART_DATA_W] & {UART_DATA_W{pick_grant_s[i]}});
            winner_last_s = winner_last_s | (req_last[i] & pick_grant_s[i]);
        end
    end

    // Accept only from IDLE with the transmitter free; the ready pulse is
    // combinational so the producer sees it in the accepting cycle.
    always_comb begin
        accept_s    = (state_q == ST_IDLE) && tx_ready && pick_found_s;
        req_ready   = accept_s ? pick_grant_s : {NUM_REQ{1'b0}};
        burst_inc_s = burst_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

    // Next-state, lock/burst bookkeeping and output register updates.
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        grant_idx_d = grant_idx_q;
        burst_cnt_d = burst_cnt_q;
        lock_d      = lock_q;
        tx_data_d   = tx_data_q;
        tx_valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d     = ST_ISSUE;
                    tx_valid_d  = 1'b1;
                    tx_data_d   = winner_data_s;
                    grant_idx_d = winner_idx_s;
                    rr_ptr_d    = (winner_idx_s == IDX_W'(NUM_REQ - 1)) ?
                                  {IDX_W{1'b0}} : (winner_idx_s + {{(IDX_W-1){1'b0}}, 1'b1});
                    if (winner_last_s) begin
                        lock_d      = 1'b0;
                        burst_cnt_d = {CNT_W{1'b0}};
                    end else if (burst_inc_s == CNT_W'(MAX_BURST)) begin
                        // Burst cap reached: force re-arbitration.
                        lock_d      = 1'b0;
                        burst_cnt_d = {CNT_W{1'b0}};
                    end else begin
                        lock_d      = 1'b1;
                        burst_cnt_d = burst_inc_s;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_WAIT_ACK;
            end
            ST_WAIT_ACK: begin
                if (!tx_ready) begin
                    state_d = ST_WAIT_DONE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            rr_ptr_q    <= {IDX_W{1'b0}};
            grant_idx_q <= {IDX_W{1'b0}};
            burst_cnt_q <= {CNT_W{1'b0}};
            lock_q      <= 1'b0;
            tx_data_q   <= {UART_DATA_W{1'b0}};
            tx_valid_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_idx_q <= grant_idx_d;
            burst_cnt_q <= burst_cnt_d;
            lock_q      <= lock_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
        end
    end

    assign tx_data_in    = tx_data_q;
    assign tx_data_valid = tx_valid_q;
    assign grant_idx     = grant_idx_q;
    assign grant_active  = lock_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a behavioural transmitter model
// and a scoreboard of expected issued bytes {lock, grant index, data}.
module tb_uart_tx_arbiter;

    localparam int NREQ = 4;
    localparam int MAXB = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic [7:0]  tx_data_in;
    logic        tx_data_valid;
    logic        tx_ready;
    logic [1:0]  grant_idx;
    logic        grant_active;
    logic        busy;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ   (NREQ),
        .MAX_BURST (MAXB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_last      (req_last),
        .req_ready     (req_ready),
        .tx_data_in    (tx_data_in),
        .tx_data_valid (tx_data_valid),
        .tx_ready      (tx_ready),
        .grant_idx     (grant_idx),
        .grant_active  (grant_active),
        .busy          (busy)
    );

    int          vectors = 0;
    int          miscompares = 0;
    logic [8:0]  src_q [NREQ][$];   // {last, data} per requester
    logic [10:0] sb_q [$];          // {lock, idx, data}
    logic [3:0]  hold;
    int          frame_cnt;
    logic [9:0]  frame_bits;
    logic        tx_line;
    logic [7:0]  rx_byte;
    logic [7:0]  line_exp;
    logic [7:0]  last_data;
    logic        expect_valid_next;
    int          issues;
    int          accepts;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int pending();
        int p = sb_q.size();
        for (int i = 0; i < NREQ; i++) p += src_q[i].size();
        return p;
    endfunction

    task automatic drive_srcs();
        logic [8:0] e;
        for (int i = 0; i < NREQ; i++) begin
            if (src_q[i].size() > 0 && !hold[i]) begin
                e = src_q[i][0];
                req_valid[i]       = 1'b1;
                req_data[i*8 +: 8] = e[7:0];
                req_last[i]        = e[8];
            end else begin
                req_valid[i]       = 1'b0;
                req_data[i*8 +: 8] = 8'h00;
                req_last[i]        = 1'b0;
            end
        end
    endtask

    // One clock: monitor at the falling edge, update models after the rise.
    task automatic tick();
        logic [3:0]  acc;
        logic        vld;
        logic [7:0]  dat;
        logic [10:0] e;
        @(negedge clk);
        if (expect_valid_next) check("issue_latency", {31'b0, tx_data_valid}, 32'd1);
        if (req_ready != 4'b0000) begin
            check("ready_onehot", {31'b0, $onehot(req_ready)}, 32'd1);
            check("ready_outside_idle", {31'b0, busy}, 32'd0);
            check("accept_while_tx_busy", {28'b0, req_ready & {4{~tx_ready}}}, 32'd0);
        end
        if (tx_data_valid) begin
            issues++;
            if (sb_q.size() == 0) begin
                check("unexpected_issue", {31'b0, tx_data_valid}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("issue_data", {24'b0, tx_data_in}, {24'b0, e[7:0]});
                check("issue_idx", {30'b0, grant_idx}, {30'b0, e[9:8]});
                check("issue_lock", {31'b0, grant_active}, {31'b0, e[10]});
                last_data = e[7:0];
                line_exp  = e[7:0];
            end
        end else if (busy) begin
            check("data_hold", {24'b0, tx_data_in}, {24'b0, last_data});
        end
        if (frame_cnt == 10) check("line_start", {31'b0, tx_line}, 32'd0);
        if (frame_cnt <= 9 && frame_cnt >= 2) rx_byte = {tx_line, rx_byte[7:1]};
        if (frame_cnt == 1) begin
            check("line_stop", {31'b0, tx_line}, 32'd1);
            check("line_byte", {24'b0, rx_byte}, {24'b0, line_exp});
        end
        acc = req_valid & req_ready;
        expect_valid_next = (acc != 4'b0000) && !rst;
        if (!rst) begin
            accepts += $countones(acc);
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) void'(src_q[i].pop_front());
            end
        end
        vld = tx_data_valid;
        dat = tx_data_in;
        @(posedge clk);
        #1;
        if (vld) begin
            frame_bits = {1'b1, dat, 1'b0};
            frame_cnt  = 10;
            tx_ready   = 1'b0;
        end else if (frame_cnt > 0) begin
            frame_cnt--;
            if (frame_cnt == 0) tx_ready = 1'b1;
        end
        tx_line = (frame_cnt > 0) ? frame_bits[4'(10 - frame_cnt)] : 1'b1;
        drive_srcs();
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_req_ready"}, {28'b0, req_ready}, 32'd0);
        check({tag, "_tx_data_in"}, {24'b0, tx_data_in}, 32'd0);
        check({tag, "_tx_data_valid"}, {31'b0, tx_data_valid}, 32'd0);
        check({tag, "_grant_idx"}, {30'b0, grant_idx}, 32'd0);
        check({tag, "_grant_active"}, {31'b0, grant_active}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_data = 8'h00;
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while (n < budget && !(pending() == 0 && !busy && frame_cnt == 0)) begin
            tick();
            n++;
        end
        check("drain_busy", {31'b0, busy}, 32'd0);
        check("drain_pending", pending(), 32'd0);
    endtask

    initial begin
        int n;
        rst = 1'b1;
        tx_ready = 1'b1;
        hold = 4'b0000;
        frame_cnt = 0;
        frame_bits = 10'h3FF;
        tx_line = 1'b1;
        rx_byte = 8'h00;
        line_exp = 8'h00;
        last_data = 8'h00;
        expect_valid_next = 1'b0;
        issues = 0;
        accepts = 0;
        drive_srcs();
        repeat (2) tick();
        rst = 1'b0;
        check_reset("por");

        // Single request from requester 1.
        accepts = 0;
        issues = 0;
        src_q[1].push_back({1'b1, 8'hA5});
        sb_q.push_back({1'b0, 2'd1, 8'hA5});
        drive_srcs();
        drain(60);
        check("single_accepts", accepts, 32'd1);
        check("single_issues", issues, 32'd1);
        check("single_grant", {30'b0, grant_idx}, 32'd1);

        // Round-robin from a fresh reset: 0,1,2,3,0,1,2,3.
        do_reset();
        check_reset("rr_rst");
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                src_q[i].push_back({1'b1, 4'(i), 4'(k)});
                sb_q.push_back({1'b0, 2'(i), 4'(i), 4'(k)});
            end
        end
        drive_srcs();
        drain(200);

        // Packet lock: requester 2 sends three bytes, requester 0 waits.
        src_q[2].push_back({1'b0, 8'h20});
        src_q[2].push_back({1'b0, 8'h21});
        src_q[2].push_back({1'b1, 8'h22});
        sb_q.push_back({1'b1, 2'd2, 8'h20});
        sb_q.push_back({1'b1, 2'd2, 8'h21});
        sb_q.push_back({1'b0, 2'd2, 8'h22});
        drive_srcs();
        tick();
        src_q[0].push_back({1'b1, 8'h01});
        src_q[0].push_back({1'b1, 8'h02});
        sb_q.push_back({1'b0, 2'd0, 8'h01});
        sb_q.push_back({1'b0, 2'd0, 8'h02});
        drive_srcs();
        drain(200);

        // Burst cap: requester 1 never sets last, requester 3 waiting.
        for (int k = 0; k < 8; k++) src_q[1].push_back({1'b0, 8'h30 + 8'(k)});
        src_q[3].push_back({1'b1, 8'h3A});
        src_q[3].push_back({1'b1, 8'h3B});
        for (int k = 0; k < 4; k++) sb_q.push_back({(k != 3), 2'd1, 8'h30 + 8'(k)});
        sb_q.push_back({1'b0, 2'd3, 8'h3A});
        for (int k = 4; k < 8; k++) sb_q.push_back({(k != 7), 2'd1, 8'h30 + 8'(k)});
        sb_q.push_back({1'b0, 2'd3, 8'h3B});
        drive_srcs();
        drain(300);

        // Reset mid-frame while a lock is held and requester 3 is pending.
        src_q[0].push_back({1'b0, 8'h40});
        src_q[3].push_back({1'b1, 8'h43});
        sb_q.push_back({1'b1, 2'd0, 8'h40});
        drive_srcs();
        issues = 0;
        n = 0;
        while (issues == 0 && n < 20) begin
            tick();
            n++;
        end
        check("midrst_issued", issues, 32'd1);
        repeat (3) tick();
        check("midrst_busy_before", {31'b0, busy}, 32'd1);
        do_reset();
        check_reset("midrst");
        sb_q.push_back({1'b0, 2'd3, 8'h43});
        drain(60);

        // Owner stall under lock: requester 0 drops valid for 20 cycles.
        src_q[0].push_back({1'b0, 8'h50});
        src_q[0].push_back({1'b0, 8'h51});
        src_q[0].push_back({1'b0, 8'h52});
        src_q[0].push_back({1'b1, 8'h53});
        src_q[1].push_back({1'b1, 8'h61});
        src_q[3].push_back({1'b1, 8'h63});
        sb_q.push_back({1'b1, 2'd0, 8'h50});
        sb_q.push_back({1'b1, 2'd0, 8'h51});
        sb_q.push_back({1'b1, 2'd0, 8'h52});
        sb_q.push_back({1'b0, 2'd0, 8'h53});
        sb_q.push_back({1'b0, 2'd1, 8'h61});
        sb_q.push_back({1'b0, 2'd3, 8'h63});
        drive_srcs();
        issues = 0;
        n = 0;
        while (issues < 2 && n < 100) begin
            tick();
            n++;
        end
        check("stall_pre_issues", issues, 32'd2);
        hold = 4'b0001;
        drive_srcs();
        issues = 0;
        repeat (20) tick();
        check("stall_issues", issues, 32'd0);
        check("stall_lock_held", {31'b0, grant_active}, 32'd1);
        check("stall_owner", {30'b0, grant_idx}, 32'd0);
        hold = 4'b0000;
        drive_srcs();
        drain(200);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
